// File: rtl/crc_seq_pkg.sv
// Shared state type and sizing helpers for the CRC frame sequencer.
package crc_seq_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned MAX_BYTES_DEF = 16;
  localparam int unsigned CRC_W_DEF     = 16;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_DROP,
    ST_STREAM,
    ST_AUGMENT,
    ST_READ,
    ST_DONE
  } crc_seq_state_t;

  // Width of a counter/index that must hold 0..n-1, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crc_frame_buffer.sv
// Frame byte store: one write port per beat and a bit-addressed read mux (MSB = bit 0).
module crc_frame_buffer
  import crc_seq_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BYTES = MAX_BYTES_DEF,
  localparam int unsigned IDX_W    = idx_w(MAX_BYTES),
  localparam int unsigned BIT_W    = idx_w(DATA_W)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [BIT_W-1:0]  rd_bit,
  output logic              rd_data_c
);

  logic [DATA_W-1:0] mem [MAX_BYTES];
  logic [DATA_W-1:0] word;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // rd_bit counts from the MSB of the stored beat.
  always_comb begin
    word      = mem[rd_idx];
    rd_data_c = word[BIT_W'(DATA_W - 1) - rd_bit];
  end

endmodule

// File: rtl/crc_frame_sequencer.sv
// Buffers a byte frame, streams it gap-free into a bit-serial CRC engine, reads the remainder back.
// CRC_SEQ_AUGMENT_EN adds the CRC_W zero-bit augmentation phase after the message.
module crc_frame_sequencer
  import crc_seq_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BYTES = MAX_BYTES_DEF,
  parameter int unsigned CRC_W     = CRC_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_LAST,
  output logic              IN_READY,
  output logic              CRC_VALID,
  output logic [CRC_W-1:0]  CRC_RESULT,
  input  logic              CRC_READY,
  output logic              ERR,
  output logic              ENG_RESET_N,
  output logic              ENG_DATA,
  output logic              ENG_READ,
  input  logic              ENG_CRC_IN
);

  localparam int unsigned IDX_W = idx_w(MAX_BYTES);
  localparam int unsigned BIT_W = idx_w(DATA_W);
  localparam int unsigned RD_W  = idx_w(CRC_W + 1);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(MAX_BYTES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [RD_W-1:0]  RD_END    = RD_W'(CRC_W);
`ifdef CRC_SEQ_AUGMENT_EN
  localparam int unsigned AUG_W = idx_w(CRC_W);
  localparam logic [AUG_W-1:0] AUG_END = AUG_W'(CRC_W - 1);
`endif

  crc_seq_state_t    state, state_nx;
  logic [IDX_W-1:0]  byte_cnt, byte_cnt_nx;
  logic [IDX_W-1:0]  last_idx, last_idx_nx;
  logic [IDX_W-1:0]  byte_idx, byte_idx_nx, nxt_byte, rd_idx;
  logic [BIT_W-1:0]  bit_idx, bit_idx_nx, nxt_bit, rd_bit;
  logic [RD_W-1:0]   rd_cnt, rd_cnt_nx;
  logic [CRC_W-1:0]  crc_nx;
  logic              in_ready_nx, crc_valid_nx, err_nx;
  logic              eng_reset_n_nx, eng_data_nx, eng_read_nx;
  logic              accept, wr_en, buf_bit;
`ifdef CRC_SEQ_AUGMENT_EN
  logic [AUG_W-1:0]  aug_cnt, aug_cnt_nx;
`endif

  assign accept = IN_VALID & IN_READY;

  // Bit after the one currently on ENG_DATA; outside STREAM we prefetch the first bit of the frame.
  always_comb begin
    if (bit_idx == LAST_BIT) begin
      nxt_byte = byte_idx + IDX_W'(1);
      nxt_bit  = '0;
    end else begin
      nxt_byte = byte_idx;
      nxt_bit  = bit_idx + BIT_W'(1);
    end
    rd_idx = (state == ST_STREAM) ? nxt_byte : '0;
    rd_bit = (state == ST_STREAM) ? nxt_bit  : '0;
  end

  crc_frame_buffer #(
    .DATA_W    (DATA_W),
    .MAX_BYTES (MAX_BYTES)
  ) u_buffer (
    .clk       (CLK),
    .wr_en     (wr_en),
    .wr_idx    (byte_cnt),
    .wr_data   (IN_DATA),
    .rd_idx    (rd_idx),
    .rd_bit    (rd_bit),
    .rd_data_c (buf_bit)
  );

  // Next-state and next-output decode; every port is a flop loaded from these.
  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    last_idx_nx = last_idx;
    byte_idx_nx = byte_idx;
    bit_idx_nx  = bit_idx;
    rd_cnt_nx   = rd_cnt;
    crc_nx      = CRC_RESULT;
    eng_data_nx = 1'b0;
    err_nx      = 1'b0;
    wr_en       = 1'b0;
`ifdef CRC_SEQ_AUGMENT_EN
    aug_cnt_nx  = aug_cnt;
`endif
    case (state)
      ST_FILL: begin
        if (accept) begin
          wr_en       = 1'b1;
          byte_cnt_nx = byte_cnt + IDX_W'(1);
          if (IN_LAST) begin
            state_nx    = ST_STREAM;
            last_idx_nx = byte_cnt;
            byte_idx_nx = '0;
            bit_idx_nx  = '0;
            // A single-beat frame lands in the buffer on this same edge, so bypass it.
            eng_data_nx = (byte_cnt == '0) ? IN_DATA[DATA_W-1] : buf_bit;
          end else if (byte_cnt == LAST_SLOT) begin
            state_nx = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (accept && IN_LAST) begin
          err_nx      = 1'b1;
          byte_cnt_nx = '0;
          state_nx    = ST_FILL;
        end
      end
      ST_STREAM: begin
        eng_data_nx = buf_bit;
        byte_idx_nx = nxt_byte;
        bit_idx_nx  = nxt_bit;
        if ((byte_idx == last_idx) && (bit_idx == LAST_BIT)) begin
          eng_data_nx = 1'b0;
          rd_cnt_nx   = '0;
`ifdef CRC_SEQ_AUGMENT_EN
          state_nx    = ST_AUGMENT;
          aug_cnt_nx  = '0;
`else
          state_nx    = ST_READ;
`endif
        end
      end
`ifdef CRC_SEQ_AUGMENT_EN
      ST_AUGMENT: begin
        aug_cnt_nx = aug_cnt + AUG_W'(1);
        if (aug_cnt == AUG_END) begin
          state_nx = ST_READ;
        end
      end
`endif
      ST_READ: begin
        rd_cnt_nx = rd_cnt + RD_W'(1);
        // Engine output trails ENG_READ by a cycle, so the first capture is at c==1.
        if (rd_cnt != '0) begin
          crc_nx = {CRC_RESULT[CRC_W-2:0], ENG_CRC_IN};
        end
        if (rd_cnt == RD_END) begin
          state_nx  = ST_DONE;
          rd_cnt_nx = '0;
        end
      end
      ST_DONE: begin
        if (CRC_VALID && CRC_READY) begin
          state_nx    = ST_FILL;
          byte_cnt_nx = '0;
        end
      end
      default: begin
        state_nx = ST_FILL;
      end
    endcase

    in_ready_nx    = (state_nx == ST_FILL) || (state_nx == ST_DROP);
    crc_valid_nx   = (state_nx == ST_DONE);
    eng_reset_n_nx = (state_nx == ST_STREAM) || (state_nx == ST_AUGMENT) || (state_nx == ST_READ);
    eng_read_nx    = (state_nx == ST_READ) && (rd_cnt_nx != RD_END);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= ST_FILL;
      byte_cnt    <= '0;
      last_idx    <= '0;
      byte_idx    <= '0;
      bit_idx     <= '0;
      rd_cnt      <= '0;
      CRC_RESULT  <= '0;
      IN_READY    <= 1'b0;
      CRC_VALID   <= 1'b0;
      ERR         <= 1'b0;
      ENG_RESET_N <= 1'b0;
      ENG_DATA    <= 1'b0;
      ENG_READ    <= 1'b0;
    end else begin
      state       <= state_nx;
      byte_cnt    <= byte_cnt_nx;
      last_idx    <= last_idx_nx;
      byte_idx    <= byte_idx_nx;
      bit_idx     <= bit_idx_nx;
      rd_cnt      <= rd_cnt_nx;
      CRC_RESULT  <= crc_nx;
      IN_READY    <= in_ready_nx;
      CRC_VALID   <= crc_valid_nx;
      ERR         <= err_nx;
      ENG_RESET_N <= eng_reset_n_nx;
      ENG_DATA    <= eng_data_nx;
      ENG_READ    <= eng_read_nx;
    end
  end

`ifdef CRC_SEQ_AUGMENT_EN
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      aug_cnt <= '0;
    end else begin
      aug_cnt <= aug_cnt_nx;
    end
  end
`endif

endmodule

// File: tb/tb_crc_frame_sequencer.sv
// Directed bench for crc_frame_sequencer with a bit-serial CRC-16 engine model on the engine ports.
module tb_crc_frame_sequencer;

`ifdef CRC_SEQ_AUGMENT_EN
  localparam int          LAT_FIX   = 33;
  localparam int          AUG_CYC   = 16;
  localparam logic [15:0] CRC_CHECK = 16'hE5CC;
  localparam logic [15:0] REF_INIT  = 16'h1D0F;
`else
  localparam int          LAT_FIX   = 17;
  localparam int          AUG_CYC   = 0;
  localparam logic [15:0] CRC_CHECK = 16'h29B1;
  localparam logic [15:0] REF_INIT  = 16'hFFFF;
`endif

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_last, crc_ready;
  logic [7:0]  in_data;
  logic        in_ready, crc_valid, err, eng_reset_n, eng_data, eng_read;
  logic [15:0] crc_result;
  logic [15:0] eng_reg;
  logic        eng_out;

  int n_tests = 0;
  int n_fail  = 0;
  int err_seen = 0, valid_seen = 0, both_seen = 0;
  logic [7:0] frm [32];

  typedef struct {
    string        name;
    int           len;
    logic [127:0] data;
    logic [15:0]  crc;
    int           lat;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  crc_frame_sequencer dut (
    .CLK         (clk),
    .RESET_N     (reset_n),
    .IN_VALID    (in_valid),
    .IN_DATA     (in_data),
    .IN_LAST     (in_last),
    .IN_READY    (in_ready),
    .CRC_VALID   (crc_valid),
    .CRC_RESULT  (crc_result),
    .CRC_READY   (crc_ready),
    .ERR         (err),
    .ENG_RESET_N (eng_reset_n),
    .ENG_DATA    (eng_data),
    .ENG_READ    (eng_read),
    .ENG_CRC_IN  (eng_out)
  );

  // Engine model: poly 0x1021, reset to 0xFFFF, registered serial readout MSB first.
  always @(posedge clk) begin
    if (!eng_reset_n) begin
      eng_reg <= 16'hFFFF;
      eng_out <= 1'b0;
    end else if (eng_read) begin
      eng_out <= eng_reg[15];
      eng_reg <= {eng_reg[14:0], 1'b0};
    end else begin
`ifdef CRC_SEQ_AUGMENT_EN
      eng_reg <= {eng_reg[14:0], eng_data} ^ (eng_reg[15] ? 16'h1021 : 16'h0000);
`else
      eng_reg <= {eng_reg[14:0], 1'b0} ^ ((eng_reg[15] ^ eng_data) ? 16'h1021 : 16'h0000);
`endif
    end
  end

  always @(negedge clk) begin
    if (err === 1'b1) err_seen++;
    if (crc_valid === 1'b1) valid_seen++;
    if (err === 1'b1 && crc_valid === 1'b1) both_seen++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Byte-wise CCITT reference over the left-aligned frame bytes.
  function automatic logic [15:0] crc_ref(input logic [127:0] d, input int n);
    logic [15:0] r;
    logic [7:0]  b;
    r = REF_INIT;
    for (int i = 0; i < n; i++) begin
      b = d[127 - 8*i -: 8];
      r = r ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  function automatic vec_t mk(input string name, input int len, input logic [127:0] data,
                              input logic [15:0] crc);
    vec_t v;
    v.name = name;
    v.len  = len;
    v.data = data;
    v.crc  = crc;
    v.lat  = 8*len + LAT_FIX;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_beats(input int n, input bit with_last);
    int guard;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frm[i];
      in_last  = with_last && (i == n - 1);
      guard = 0;
      while (in_ready !== 1'b1 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) begin
        check("in_ready wait", 32'(in_ready), 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Follows one frame from the cycle after IN_LAST acceptance through the DONE handshake.
  task automatic watch_frame(input string name, input int n, input logic [15:0] exp_crc,
                             input int exp_lat, input int hold);
    int j, lat, bit_err, phase_err, rd_hi, rd_first, stable_err, idx;
    logic eb;
    logic [15:0] held;
    j = 0; lat = -1; bit_err = 0; phase_err = 0; rd_hi = 0; rd_first = -1; stable_err = 0;
    crc_ready = (hold == 0);
    while (lat < 0 && j < exp_lat + 50) begin
      @(negedge clk);
      j++;
      if (crc_valid === 1'b1) begin
        lat = j - 1;
      end else begin
        if (in_ready !== 1'b0 || eng_reset_n !== 1'b1 || err !== 1'b0) phase_err++;
        if (j <= 8*n) begin
          idx = j - 1;
          eb  = frm[idx/8][7 - (idx%8)];
          if (eng_data !== eb || eng_read !== 1'b0) bit_err++;
        end else if (eng_data !== 1'b0) begin
          phase_err++;
        end
        if (eng_read === 1'b1) begin
          rd_hi++;
          if (rd_first < 0) rd_first = j;
        end
      end
    end
    check($sformatf("%s latency", name), lat, exp_lat);
    check($sformatf("%s stream bits", name), bit_err, 0);
    check($sformatf("%s busy-phase outputs", name), phase_err, 0);
    check($sformatf("%s read start", name), rd_first, 8*n + 1 + AUG_CYC);
    check($sformatf("%s read cycles", name), rd_hi, 16);
    check($sformatf("%s crc", name), 32'(crc_result), 32'(exp_crc));
    held = crc_result;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (crc_valid !== 1'b1 || crc_result !== held || in_ready !== 1'b0) stable_err++;
    end
    if (hold > 0) check($sformatf("%s hold stable", name), stable_err, 0);
    crc_ready = 1'b1;
    @(negedge clk);
    check($sformatf("%s release to fill", name), {30'd0, crc_valid, in_ready}, 32'b01);
  endtask

  task automatic run_vec(input int i, input int hold);
    for (int k = 0; k < vecs[i].len; k++) frm[k] = vecs[i].data[127 - 8*k -: 8];
    push_beats(vecs[i].len, 1'b1);
    watch_frame(vecs[i].name, vecs[i].len, vecs[i].crc, vecs[i].lat, hold);
  endtask

  initial begin
    logic [127:0] d;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    crc_ready = 1'b1;

    vecs[0] = mk("check123", 9, {72'h313233343536373839, 56'h0}, CRC_CHECK);
    d = {8'h00, 120'h0};  vecs[1] = mk("single00", 1, d, crc_ref(d, 1));
    d = {8'h31, 120'h0};  vecs[2] = mk("single31", 1, d, crc_ref(d, 1));
    d = {8'hAA, 120'h0};  vecs[3] = mk("singleAA", 1, d, crc_ref(d, 1));
    d = 128'h0102030405060708090A0B0C0D0E0F10;
    vecs[4] = mk("max16", 16, d, crc_ref(d, 16));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {26'd0, in_ready, crc_valid, err, eng_reset_n, eng_data, eng_read}, 0);
    check("reset crc_result", 32'(crc_result), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", 32'(in_ready), 1);

    for (int i = 0; i < 5; i++) run_vec(i, 0);

    // Overflow: 17 beats without IN_LAST, then one with it.
    for (int i = 0; i < 18; i++) frm[i] = 8'(8'h40 + i);
    err_seen = 0;
    valid_seen = 0;
    push_beats(18, 1'b1);
    repeat (5) @(negedge clk);
    check("overflow err pulses", err_seen, 1);
    check("overflow crc_valid", valid_seen, 0);
    check("overflow back in fill", 32'(in_ready), 1);
    run_vec(3, 0);

    run_vec(0, 10);

    // Reset asserted while the engine is past the message bits.
    frm[0] = 8'h31;
    frm[1] = 8'h32;
    push_beats(2, 1'b1);
    repeat (21) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset outputs", {26'd0, in_ready, crc_valid, err, eng_reset_n, eng_data, eng_read}, 0);
    check("midreset crc_result", 32'(crc_result), 0);
    reset_n = 1'b1;
    err_seen = 0;
    valid_seen = 0;
    @(negedge clk);
    check("midreset in_ready", 32'(in_ready), 1);
    repeat (120) @(negedge clk);
    check("midreset no valid/err", valid_seen + err_seen, 0);
    run_vec(2, 0);

    check("err with crc_valid", both_seen, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_frame_sequencer.md
# crc_frame_sequencer

- Frame-level controller for the bit-serial CRC-16 engine.
- Accepts a frame of bytes over a valid/ready stream and buffers it. The engine has no hold/enable, so the frame must then be streamed MSB-first into it without gaps.
- Optionally appends 16 zero augmentation bits, reads the 16-bit remainder back out of the engine serially, and presents it as a parallel result with valid/ready.
- Sits between the byte-stream source and the engine; it owns all of the engine's control inputs.

## Interface

Parameters:
- DATA_W, 8, bits per input beat.
- MAX_BYTES, 16, buffer depth in beats (power of 2 not required).
- CRC_W, 16, engine register width and result width.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  reset, synchronous, active-low.
- IN_VALID  in  1  input beat valid.
- IN_DATA  in  DATA_W  input beat.
- IN_LAST  in  1  final beat of frame.
- IN_READY  out  1  beat accepted when IN_VALID & IN_READY.
- CRC_VALID  out  1  CRC_RESULT valid.
- CRC_RESULT  out  CRC_W  remainder, MSB = first bit read from engine.
- CRC_READY  in  1  result consumed when CRC_VALID & CRC_READY.
- ERR  out  1  one-cycle pulse on overflow frame drop.
- ENG_RESET_N  out  1  to engine RESET_N.
- ENG_DATA  out  1  to engine DATA_IN.
- ENG_READ  out  1  to engine READ_MODE.
- ENG_CRC_IN  in  1  from engine CRC_OUT.

## Operation

- States: FILL, DROP, STREAM, AUGMENT, READ, DONE.
- All outputs are decoded from flops only; there is no combinational input-to-output path.

FILL
- IN_READY=1; ENG_RESET_N=0, which holds the engine at 0xFFFF.
- Each accepted beat is written at index byte_cnt and byte_cnt is incremented.
- Accepted beat with IN_LAST → STREAM, with n_bytes = byte_cnt+1.
- Accepted beat without IN_LAST while byte_cnt==MAX_BYTES-1 → DROP.

DROP
- IN_READY=1; beats are discarded.
- Accepted IN_LAST → ERR=1 for one cycle, byte_cnt=0, → FILL.

STREAM
- ENG_RESET_N=1, ENG_READ=0.
- ENG_DATA = buffer[byte_idx][DATA_W-1-bit_idx], one bit per cycle, exactly n_bytes*DATA_W cycles, no gaps.
- On the final bit → AUGMENT, or → READ when augmentation is compiled out.

AUGMENT
- ENG_DATA=0 for CRC_W cycles → READ.

READ
- Counter c runs 0..CRC_W.
- ENG_READ=1 while c<CRC_W, else 0.
- At the end of each cycle with c≥1: CRC_RESULT ← {CRC_RESULT[CRC_W-2:0], ENG_CRC_IN}. The engine output lags ENG_READ by one cycle.
- After c==CRC_W → DONE.

DONE
- CRC_VALID=1; ENG_RESET_N=0; IN_READY=0.
- CRC_RESULT is held stable.
- CRC_VALID & CRC_READY → FILL, byte_cnt=0. CRC_RESULT keeps its value until the next READ.

Other rules:
- IN_READY=0 in STREAM, AUGMENT, READ and DONE.
- Frame length is 1..MAX_BYTES; an empty frame is impossible by construction.
- A single-beat frame with IN_LAST set goes directly FILL → STREAM.
- ERR and CRC_VALID are never simultaneous.

## Timing

- Reset values: state FILL, IN_READY=0, CRC_VALID=0, CRC_RESULT=0, ERR=0, ENG_RESET_N=0, ENG_DATA=0, ENG_READ=0, all counters 0.
- IN_READY=1 from the first cycle after RESET_N goes high.
- Latency: the first STREAM cycle is the cycle after the edge that accepts the IN_LAST beat.
  - With augmentation, CRC_VALID rises 8N+CRC_W+CRC_W+1 cycles later (N = n_bytes, DATA_W=8). For CRC_W=16 this is 8N+33.
  - Without augmentation it is 8N+17.
- Throughput: back-to-back frames are separated by at least one FILL cycle. That cycle guarantees the engine reset edge.
- RESET_N low in any state → next cycle is in the reset state. This discards the partial frame and any pending result, with no ERR.
- CRC_READY held high: DONE lasts exactly one cycle.

## Configuration

- Macro: CRC_SEQ_AUGMENT_EN.
- Defined: the AUGMENT state exists and CRC_W zero bits are appended after the message. Use this for the shift-into-LSB engine form.
- Undefined: the AUGMENT state and its counter are not synthesised; STREAM goes directly to READ. Use this for direct-form engines.
- Default build defines it.

## Structure

- Package crc_seq_pkg holds:
  - the state enum (crc_seq_state_t);
  - CRC_W default 16;
  - the counter-width helper constants.
- Sub-module crc_frame_buffer holds the MAX_BYTES×DATA_W register array, the write port and the bit-indexed read mux. It is instantiated once.
- The FSM, counters and result shifter stay in crc_frame_sequencer.

## Test plan

- **Reset:** reset, then one frame 0x31..0x39 ("123456789", IN_LAST on 0x39). Checks:
  - IN_READY low during reset;
  - 72 contiguous ENG_DATA bits matching the MSB-first pattern;
  - CRC_VALID exactly 105 cycles after the IN_LAST acceptance;
  - CRC_RESULT equals the bit-accurate engine model.
- **Single beat:** frame 0x00 with IN_LAST → STREAM 8 cycles, AUGMENT 16, ENG_READ high 16 cycles; CRC_VALID 41 cycles after acceptance.
- **Overflow:** 17 beats with no IN_LAST, then a beat with IN_LAST → ERR one pulse; no CRC_VALID; the next frame 0xAA computes normally.
- **Backpressure:** CRC_READY held low 10 cycles in DONE → CRC_VALID and CRC_RESULT stable, IN_READY=0; release → FILL next cycle.
- **Reset mid-operation:** RESET_N low during AUGMENT → all outputs return to reset values; no CRC_VALID; the following frame is correct.
- **Augmentation compiled out:** build without CRC_SEQ_AUGMENT_EN, frame 0x31 → CRC_VALID 25 cycles after acceptance; no zero-bit phase.
